memory_access_controller: RTL

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

---
 rtl/memory_access_controller.sv | 57 +++++
 1 files changed

// File: rtl/memory_access_controller.sv
// memory_access_controller: flow control between a producer, a sequential memory and a consumer
module memory_access_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         request_write,
   output logic                         request_read,
   output logic [DATA_WIDTH-1:0]        mem_data_in,
   input  logic [DATA_WIDTH-1:0]        mem_data_out,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int CW = $clog2(DEPTH+1);
   logic rd_pending;
   logic rd_go;
   // Handshake decode: a read beats a write, and nothing is accepted while reset is held
   always_comb begin
      full          = count == CW'(DEPTH);
      empty         = count == '0;
      rd_go         = !empty && !out_valid && !rd_pending;
      request_read  = rd_go;
      in_ready      = reset && !full && !rd_go;
      request_write = in_valid && in_ready;
      mem_data_in   = in_data;
   end
   // Words currently held in memory; strobes are mutually exclusive and gated by full/empty
   always_ff @(posedge clk or negedge reset)
      if (!reset)
         count <= '0;
      else if (request_write)
         count <= count + CW'(1);
      else if (request_read)
         count <= count - CW'(1);
   // Read pipeline: strobe, then memory data, then captured output held until taken
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rd_pending <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         rd_pending <= request_read;
         if (rd_pending) begin
            out_data  <= mem_data_out;
            out_valid <= 1'b1;
         end else if (out_ready)
            out_valid <= 1'b0;
      end
endmodule
